player_sprite_writer: RTL and testbench

- Framebuffer-side writer for the player marker. On a start pulse it latches a player position and erases the sprite at the previously drawn position. It then paints a rectangular sprite at the new position.
- Emits one RGB444 pixel write per accepted handshake into the 640x480 frame buffer, using linear address y*640+x.
- Sits between game logic (position source) and the frame-buffer write port. It feeds the same 19-bit address / 12-bit pixel format the pixel-stream scanners consume.

---
 rtl/player_sprite_writer.sv | 218 +++++++++++++++++++++
 tb/tb_player_sprite_writer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_sprite_writer.sv
// rtl/player_sprite_writer.sv - erase/redraw writer for the player sprite into a 640x480 RGB444 frame buffer
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     redraw request, sampled only while idle
//   pos_x     new sprite top-left x, sampled with start
//   pos_y     new sprite top-left y, sampled with start
//   wr_ready  frame buffer accepts the presented write
//   wr_en     write request valid
//   wr_addr   linear pixel address y*IMAGE_WIDTH+x
//   wr_data   RGB444 pixel value
//   busy      high while erasing or drawing
//   done      one-cycle pulse when a redraw completes
module player_sprite_writer #(
    parameter int          IMAGE_WIDTH  = 640,
    parameter int          IMAGE_HEIGHT = 480,
    parameter int          SPRITE_W     = 16,
    parameter int          SPRITE_H     = 16,
    parameter logic [11:0] DRAW_COLOR   = 12'hF00,
    parameter logic [11:0] ERASE_COLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  pos_x,
    input  logic [8:0]  pos_y,
    input  logic        wr_ready,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_FIN} state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic [9:0]  r_cur_x;
    logic [8:0]  r_cur_y;
    logic [18:0] r_cur_base;
    logic [9:0]  r_prev_x;
    logic [8:0]  r_prev_y;
    logic [18:0] r_prev_base;
    logic        r_prev_valid;

    // Current slot: indices, pixel coordinate and linear address (address is
    // meaningless for clipped slots, which never drive wr_en).
    logic [5:0]  r_col;
    logic [5:0]  r_row;
    logic [10:0] r_px;
    logic [9:0]  r_py;
    logic [18:0] r_addr;
    logic [11:0] r_color;

    logic        r_wr_en;
    logic [18:0] r_wr_addr;
    logic [11:0] r_wr_data;
    logic        r_busy;
    logic        r_done;

    logic        w_in_scan;
    logic        w_slot_done;
    logic        w_last_slot;
    logic        w_pass_end;
    logic [18:0] w_start_base;

    logic [5:0]  w_col;
    logic [5:0]  w_row;
    logic [10:0] w_px;
    logic [9:0]  w_py;
    logic [18:0] w_addr;
    logic [11:0] w_color;
    logic        w_scan_nx;
    logic        w_in_range;
    logic        w_wr_en_nx;
    logic [18:0] w_wr_addr_nx;
    logic [11:0] w_wr_data_nx;
    logic        w_busy_nx;
    logic        w_done_nx;

    // A presented write finishes on acceptance; a clipped slot (wr_en low)
    // finishes after its single cycle regardless of wr_ready.
    assign w_in_scan   = (r_state == S_ERASE) || (r_state == S_DRAW);
    assign w_slot_done = w_in_scan && (!r_wr_en || wr_ready);
    assign w_last_slot = (r_col == 6'(SPRITE_W - 1)) && (r_row == 6'(SPRITE_H - 1));
    assign w_pass_end  = w_slot_done && w_last_slot;

    // Constant-coefficient product, only needed once per redraw for the origin;
    // every later slot address is derived incrementally.
    assign w_start_base = 19'(pos_y) * 19'(IMAGE_WIDTH) + 19'(pos_x);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nx = r_prev_valid ? S_ERASE : S_DRAW;
            S_ERASE: if (w_pass_end) w_state_nx = S_DRAW;
            S_DRAW:  if (w_pass_end) w_state_nx = S_FIN;
            S_FIN:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_col   = r_col;
        w_row   = r_row;
        w_px    = r_px;
        w_py    = r_py;
        w_addr  = r_addr;
        w_color = r_color;
        if (r_state == S_IDLE && start) begin
            w_col = '0;
            w_row = '0;
            if (r_prev_valid) begin
                w_px    = {1'b0, r_prev_x};
                w_py    = {1'b0, r_prev_y};
                w_addr  = r_prev_base;
                w_color = ERASE_COLOR;
            end else begin
                w_px    = {1'b0, pos_x};
                w_py    = {1'b0, pos_y};
                w_addr  = w_start_base;
                w_color = DRAW_COLOR;
            end
        end else if (r_state == S_ERASE && w_pass_end) begin
            // Erase finished: first draw slot follows with no gap cycle.
            w_col   = '0;
            w_row   = '0;
            w_px    = {1'b0, r_cur_x};
            w_py    = {1'b0, r_cur_y};
            w_addr  = r_cur_base;
            w_color = DRAW_COLOR;
        end else if (w_slot_done && !w_last_slot) begin
            if (r_col == 6'(SPRITE_W - 1)) begin
                w_col  = '0;
                w_row  = r_row + 6'd1;
                w_px   = r_px - 11'(SPRITE_W - 1);
                w_py   = r_py + 10'd1;
                w_addr = r_addr + 19'(IMAGE_WIDTH) - 19'(SPRITE_W - 1);
            end else begin
                w_col  = r_col + 6'd1;
                w_px   = r_px + 11'd1;
                w_addr = r_addr + 19'd1;
            end
        end

        w_scan_nx    = (w_state_nx == S_ERASE) || (w_state_nx == S_DRAW);
        w_in_range   = (w_px < 11'(IMAGE_WIDTH)) && (w_py < 10'(IMAGE_HEIGHT));
        w_wr_en_nx   = w_scan_nx && w_in_range;
        w_wr_addr_nx = w_wr_en_nx ? w_addr : '0;
        w_wr_data_nx = w_wr_en_nx ? w_color : '0;
        w_busy_nx    = w_scan_nx;
        w_done_nx    = (w_state_nx == S_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_cur_base   <= '0;
            r_prev_x     <= '0;
            r_prev_y     <= '0;
            r_prev_base  <= '0;
            r_prev_valid <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_addr       <= '0;
            r_color      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_col     <= w_col;
            r_row     <= w_row;
            r_px      <= w_px;
            r_py      <= w_py;
            r_addr    <= w_addr;
            r_color   <= w_color;
            r_wr_en   <= w_wr_en_nx;
            r_wr_addr <= w_wr_addr_nx;
            r_wr_data <= w_wr_data_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            if (r_state == S_IDLE && start) begin
                r_cur_x    <= pos_x;
                r_cur_y    <= pos_y;
                r_cur_base <= w_start_base;
            end
            if (r_state == S_FIN) begin
                r_prev_x     <= r_cur_x;
                r_prev_y     <= r_cur_y;
                r_prev_base  <= r_cur_base;
                r_prev_valid <= 1'b1;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_player_sprite_writer.sv
// tb/tb_player_sprite_writer.sv - scoreboard bench for player_sprite_writer with a 4x4 sprite
module tb_player_sprite_writer;

    localparam int          MAXC = 200;
    localparam logic [11:0] DRAW_C  = 12'hF00;
    localparam logic [11:0] ERASE_C = 12'h000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic        wr_ready;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;

    player_sprite_writer #(
        .IMAGE_WIDTH (640),
        .IMAGE_HEIGHT(480),
        .SPRITE_W    (4),
        .SPRITE_H    (4),
        .DRAW_COLOR  (12'hF00),
        .ERASE_COLOR (12'h000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pos_x   (pos_x),
        .pos_y   (pos_y),
        .wr_ready(wr_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [30:0] exp_q[$];
    logic        m_valid;
    int          m_x;
    int          m_y;

    logic        s_en;
    logic [18:0] s_addr;
    logic [11:0] s_data;
    logic        s_busy;
    logic        s_done;

    logic        tr_en   [0:MAXC];
    logic [18:0] tr_addr [0:MAXC];
    logic [11:0] tr_data [0:MAXC];

    task automatic push_sprite(input int ox, input int oy, input logic [11:0] col);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int px;
                int py;
                px = ox + c;
                py = oy + r;
                if (px < 640 && py < 480) exp_q.push_back({19'(py * 640 + px), col});
            end
        end
    endtask

    task automatic push_redraw(input int x, input int y);
        if (m_valid) push_sprite(m_x, m_y, ERASE_C);
        push_sprite(x, y, DRAW_C);
        m_x = x;
        m_y = y;
        m_valid = 1'b1;
    endtask

    // Samples the current cycle at the falling edge, retires an accepted write
    // against the scoreboard, then moves to just after the next rising edge.
    task automatic step();
        logic [30:0] e;
        @(negedge clk);
        s_en   = wr_en;
        s_addr = wr_addr;
        s_data = wr_data;
        s_busy = busy;
        s_done = done;
        if (rst === 1'b0 && wr_en === 1'b1 && wr_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_write: got addr=%0d data=%03h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_err++;
                    $display("FAIL sb_write: got addr=%0d data=%03h, expected addr=%0d data=%03h",
                             wr_addr, wr_data, e[30:12], e[11:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        wr_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
        m_valid = 1'b0;
        step();
    endtask

    task automatic drive_redraw(input int x, input int y, input int stall_at, input int stall_len,
                                input int extra_at, output int dcyc, output logic busy_d,
                                output logic done_next);
        dcyc = -1;
        busy_d = 1'bx;
        done_next = 1'bx;
        pos_x = 10'(x);
        pos_y = 9'(y);
        wr_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= MAXC && dcyc < 0; k++) begin
            wr_ready = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1;
            if (k == extra_at) begin
                start = 1'b1;
                pos_x = 10'd300;
                pos_y = 9'd300;
            end
            step();
            start = 1'b0;
            tr_en[k]   = s_en;
            tr_addr[k] = s_addr;
            tr_data[k] = s_data;
            if (s_done === 1'b1) begin
                dcyc = k;
                busy_d = s_busy;
            end
        end
        wr_ready = 1'b1;
        step();
        done_next = s_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        pos_x = '0;
        pos_y = '0;
        wr_ready = 1'b1;
        m_valid = 1'b0;
        step();
        step();
        n_cmp++;
        if ({s_en, s_addr, s_data, s_busy, s_done} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%03h busy=%b done=%b, expected all 0",
                     s_en, s_addr, s_data, s_busy, s_done);
        end
        rst = 1'b0;
        step();
        step();
        n_cmp++;
        if ({s_en, s_busy, s_done} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset: got en=%b busy=%b done=%b, expected 0 0 0", s_en, s_busy, s_done);
        end
    endtask

    task automatic test_first_draw();
        int dc;
        logic bd;
        logic dn;
        push_redraw(10, 2);
        drive_redraw(10, 2, 0, 0, 0, dc, bd, dn);
        n_cmp++;
        if (dc !== 17) begin
            n_err++;
            $display("FAIL first_done_cycle: got %0d, expected 17", dc);
        end
        n_cmp++;
        if (!(tr_en[1] === 1'b1 && tr_addr[1] === 19'd1290 && tr_data[1] === DRAW_C)) begin
            n_err++;
            $display("FAIL first_write_latency: got en=%b addr=%0d data=%03h in cycle 1, expected 1 1290 f00",
                     tr_en[1], tr_addr[1], tr_data[1]);
        end
        n_cmp++;
        if (bd !== 1'b0 || dn !== 1'b0) begin
            n_err++;
            $display("FAIL first_busy_done: got busy_at_done=%b done_next=%b, expected 0 0", bd, dn);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL first_write_count: got %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_move();
        int dc;
        logic bd;
        logic dn;
        int gaps;
        push_redraw(20, 2);
        drive_redraw(20, 2, 0, 0, 0, dc, bd, dn);
        n_cmp++;
        if (dc !== 33) begin
            n_err++;
            $display("FAIL move_done_cycle: got %0d, expected 33", dc);
        end
        gaps = 0;
        for (int k = 1; k <= 32; k++) if (tr_en[k] !== 1'b1) gaps++;
        n_cmp++;
        if (gaps != 0) begin
            n_err++;
            $display("FAIL move_no_gap: got %0d idle cycles in 32, expected 0", gaps);
        end
        n_cmp++;
        if (!(tr_addr[16] === 19'd3213 && tr_data[16] === ERASE_C && tr_addr[17] === 19'd1300 && tr_data[17] === DRAW_C)) begin
            n_err++;
            $display("FAIL move_seam: got %0d/%03h then %0d/%03h, expected 3213/000 then 1300/f00",
                     tr_addr[16], tr_data[16], tr_addr[17], tr_data[17]);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL move_write_count: got %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int dc;
        logic bd;
        logic dn;
        do_reset();
        push_redraw(40, 10);
        drive_redraw(40, 10, 6, 3, 0, dc, bd, dn);
        n_cmp++;
        if (dc !== 20) begin
            n_err++;
            $display("FAIL stall_done_cycle: got %0d, expected 20", dc);
        end
        for (int k = 6; k <= 9; k++) begin
            n_cmp++;
            if (!(tr_en[k] === 1'b1 && tr_addr[k] === 19'd7081 && tr_data[k] === DRAW_C)) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: got en=%b addr=%0d data=%03h, expected 1 7081 f00",
                         k, tr_en[k], tr_addr[k], tr_data[k]);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_write_count: got %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_busy_ignore();
        int dc;
        logic bd;
        logic dn;
        int stray;
        push_redraw(50, 10);
        drive_redraw(50, 10, 0, 0, 20, dc, bd, dn);
        n_cmp++;
        if (dc !== 33) begin
            n_err++;
            $display("FAIL busy_start_done_cycle: got %0d, expected 33", dc);
        end
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_en !== 1'b0 || s_busy !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL busy_start_queued: got %0d active cycles after done, expected 0", stray);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL busy_write_count: got %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_clipping();
        int dc;
        logic bd;
        logic dn;
        int nclip;
        do_reset();
        push_redraw(638, 478);
        drive_redraw(638, 478, 0, 0, 0, dc, bd, dn);
        n_cmp++;
        if (dc !== 17) begin
            n_err++;
            $display("FAIL clip_done_cycle: got %0d, expected 17", dc);
        end
        nclip = 0;
        for (int k = 1; k <= 16; k++) if (tr_en[k] === 1'b0) nclip++;
        n_cmp++;
        if (nclip != 12) begin
            n_err++;
            $display("FAIL clip_idle_slots: got %0d, expected 12", nclip);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL clip_write_count: got %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        logic bd;
        logic dn;
        push_redraw(100, 50);
        pos_x = 10'd100;
        pos_y = 9'd50;
        wr_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 19; k++) step();
        n_cmp++;
        if (!(s_en === 1'b1 && s_data === DRAW_C && s_busy === 1'b1)) begin
            n_err++;
            $display("FAIL mid_in_draw: got en=%b data=%03h busy=%b, expected 1 f00 1", s_en, s_data, s_busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({wr_en, wr_addr, wr_data, busy, done} !== 34'd0) begin
            n_err++;
            $display("FAIL mid_reset_async: got en=%b addr=%0d data=%03h busy=%b done=%b, expected all 0",
                     wr_en, wr_addr, wr_data, busy, done);
        end
        step();
        rst = 1'b0;
        exp_q.delete();
        m_valid = 1'b0;
        step();
        push_redraw(0, 0);
        drive_redraw(0, 0, 0, 0, 0, dc, bd, dn);
        n_cmp++;
        if (dc !== 17) begin
            n_err++;
            $display("FAIL mid_no_erase_done_cycle: got %0d, expected 17", dc);
        end
        n_cmp++;
        if (!(tr_addr[1] === 19'd0 && tr_addr[5] === 19'd640 && tr_data[1] === DRAW_C)) begin
            n_err++;
            $display("FAIL mid_no_erase_addr: got %0d,%0d data=%03h, expected 0,640 f00",
                     tr_addr[1], tr_addr[5], tr_data[1]);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL mid_write_count: got %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_move();
        test_backpressure();
        test_busy_ignore();
        test_clipping();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit, expected summary before it");
        $fatal(1, "watchdog");
    end

endmodule
